// File: rtl/ip_boot_seq.sv
// Boot sequencer: samples the ip_sel pad until it is stable, then brings the selected IP
// up (clock on, reset hold, reset release, pad enable). Tears it down again on sw restart.
module ip_boot_seq #(
  parameter int SAMPLE_CYC = 16,
  parameter int CLK_SETTLE = 8,
  parameter int RST_HOLD   = 16,
  parameter int PAD_DELAY  = 4
) (
  input  logic       sys_clk_i,
  input  logic       arst_n_i,
  input  logic [2:0] ip_sel_i,
  input  logic [7:0] ip_avail_i,
  input  logic       sw_restart_i,
  output logic [7:0] ip_clk_en_o,
  output logic [7:0] ip_rst_n_o,
  output logic       pad_oe_en_o,
  output logic [2:0] ip_sel_q_o,
  output logic [2:0] state_o,
  output logic       err_o,
  output logic       sel_mismatch_o
);

  typedef enum logic [2:0] {
    S_SAMPLE   = 3'd0,
    S_CLK_ON   = 3'd1,
    S_RST_HOLD = 3'd2,
    S_PAD_WAIT = 3'd3,
    S_RUN      = 3'd4,
    S_TEARDOWN = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  localparam logic [7:0] SAMPLE_LIM = 8'(SAMPLE_CYC);
  localparam logic [7:0] SETTLE_END = 8'(CLK_SETTLE - 1);
  localparam logic [7:0] HOLD_END   = 8'(RST_HOLD - 1);
  localparam logic [7:0] PAD_END    = 8'(PAD_DELAY - 1);

  state_e     state_q;
  logic [2:0] sync1_q, sync2_q, prev_q, sel_q;
  logic [7:0] stab_q, stab_d, cnt_q;
  logic [7:0] clk_en_q, rst_n_q;
  logic       pad_q, err_q, mm_q;

  // Stable-run length of the synchronized select, including the current cycle.
  assign stab_d = (sync2_q == prev_q) ? stab_q + 8'd1 : 8'd0;

  always_ff @(posedge sys_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= S_SAMPLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      sel_q    <= '0;
      stab_q   <= '0;
      cnt_q    <= '0;
      clk_en_q <= '0;
      rst_n_q  <= '0;
      pad_q    <= 1'b0;
      err_q    <= 1'b0;
      mm_q     <= 1'b0;
    end else begin
      sync1_q <= ip_sel_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      case (state_q)
        S_SAMPLE: begin
          if (stab_d == SAMPLE_LIM) begin
            stab_q <= '0;
            cnt_q  <= '0;
            sel_q  <= sync2_q;
            if (ip_avail_i[sync2_q]) begin
              clk_en_q <= 8'd1 << sync2_q;
              state_q  <= S_CLK_ON;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end
          end else begin
            stab_q <= stab_d;
          end
        end
        S_CLK_ON: begin
          if (cnt_q == SETTLE_END) begin
            cnt_q   <= '0;
            state_q <= S_RST_HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RST_HOLD: begin
          if (cnt_q == HOLD_END) begin
            cnt_q   <= '0;
            rst_n_q <= 8'd1 << sel_q;
            state_q <= S_PAD_WAIT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_PAD_WAIT: begin
          if (cnt_q == PAD_END) begin
            cnt_q   <= '0;
            pad_q   <= 1'b1;
            state_q <= S_RUN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          // Mismatch is reported only; the running IP is never reconfigured by the pad.
          mm_q <= (sync2_q != sel_q);
          if (sw_restart_i) begin
            pad_q   <= 1'b0;
            rst_n_q <= '0;
            mm_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_TEARDOWN;
          end
        end
        S_TEARDOWN: begin
          if (cnt_q == SETTLE_END) begin
            cnt_q    <= '0;
            clk_en_q <= '0;
            stab_q   <= '0;
            state_q  <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_ERROR: begin
          if (sw_restart_i) begin
            err_q   <= 1'b0;
            stab_q  <= '0;
            state_q <= S_SAMPLE;
          end
        end
        default: begin
          state_q  <= S_SAMPLE;
          stab_q   <= '0;
          cnt_q    <= '0;
          clk_en_q <= '0;
          rst_n_q  <= '0;
          pad_q    <= 1'b0;
          err_q    <= 1'b0;
          mm_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ip_clk_en_o    = clk_en_q;
  assign ip_rst_n_o     = rst_n_q;
  assign pad_oe_en_o    = pad_q;
  assign ip_sel_q_o     = sel_q;
  assign state_o        = state_q;
  assign err_o          = err_q;
  assign sel_mismatch_o = mm_q;

endmodule

// File: doc/ip_boot_seq.md
IP_BOOT_SEQ -- requirements
Module: ip_boot_seq

Interface
REQ-001 SHALL have parameter SAMPLE_CYC, default 16, meaning consecutive stable cycles of ip_sel required before it is latched (range 2..255).
REQ-002 SHALL have parameter CLK_SETTLE, default 8, meaning cycles the IP clock runs before the reset-hold phase and before clock-off at teardown (range 1..255).
REQ-003 SHALL have parameter RST_HOLD, default 16, meaning cycles the IP reset stays asserted with its clock running (range 1..255).
REQ-004 SHALL have parameter PAD_DELAY, default 4, meaning cycles between IP reset release and pad output-enable (range 1..255).
REQ-005 sys_clk_i  input  1  single block clock.
REQ-006 arst_n_i  input  1  asynchronous active-low reset.
REQ-007 ip_sel_i  input  3  raw ip_sel pad value, asynchronous to sys_clk_i.
REQ-008 ip_avail_i  input  8  bit n = 1 when IP n is instantiated (static).
REQ-009 sw_restart_i  input  1  single-cycle restart request.
REQ-010 ip_clk_en_o  output  8  one-hot clock-gate enable, bit = latched select.
REQ-011 ip_rst_n_o  output  8  per-IP active-low reset.
REQ-012 pad_oe_en_o  output  1  global qualifier ANDed with io_pad_oe.
REQ-013 ip_sel_q_o  output  3  latched IP select.
REQ-014 state_o  output  3  FSM state code.
REQ-015 err_o  output  1  selected IP not available.
REQ-016 sel_mismatch_o  output  1  pad ip_sel differs from latched value while in RUN.

Function
REQ-017 ip_sel_i SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value.
REQ-018 Every output SHALL be driven directly from a flop.
REQ-019 States and codes SHALL be: SAMPLE=0, CLK_ON=1, RST_HOLD=2, PAD_WAIT=3, RUN=4, TEARDOWN=5, ERROR=6; code 7 SHALL never be reached and SHALL recover to SAMPLE.
REQ-020 SAMPLE: the stable counter SHALL increment each cycle the synchronized sel equals its previous-cycle value and SHALL clear to 0 on any change.
REQ-021 SAMPLE: when the counter reaches SAMPLE_CYC, the synchronized sel SHALL be latched into ip_sel_q_o, then the FSM SHALL go to CLK_ON if ip_avail_i[sel]=1, else to ERROR.
REQ-022 Each timed state (CLK_ON, RST_HOLD, PAD_WAIT) SHALL clear its 8-bit counter on entry and SHALL last exactly its parameter in cycles.
REQ-023 CLK_ON: ip_clk_en_o[sel_q] SHALL be 1 and all ip_rst_n_o SHALL be 0.
REQ-024 RST_HOLD SHALL have the same outputs as CLK_ON, lasting RST_HOLD cycles.
REQ-025 On leaving RST_HOLD: ip_rst_n_o[sel_q] SHALL go 1, and the FSM SHALL enter PAD_WAIT.
REQ-026 On leaving PAD_WAIT: pad_oe_en_o SHALL go 1, and the FSM SHALL enter RUN.
REQ-027 RUN: the outputs SHALL hold, and sel_mismatch_o SHALL equal (synchronized sel != ip_sel_q_o), registered; a mismatch SHALL NOT trigger reconfiguration.
REQ-028 sw_restart_i in RUN SHALL enter TEARDOWN.
REQ-029 TEARDOWN entry, same cycle: pad_oe_en_o=0 and all ip_rst_n_o=0.
REQ-030 TEARDOWN: ip_clk_en_o SHALL hold for CLK_SETTLE cycles and then clear to 0; the FSM SHALL then go to SAMPLE with the stable counter cleared.
REQ-031 ERROR: err_o=1, all enables 0, all resets asserted; sw_restart_i SHALL clear err_o and go to SAMPLE.
REQ-032 sw_restart_i SHALL be ignored in SAMPLE, CLK_ON, RST_HOLD, PAD_WAIT and TEARDOWN.
REQ-033 At most one ip_clk_en_o bit and at most one ip_rst_n_o bit SHALL ever be 1.
REQ-034 pad_oe_en_o SHALL be 1 only when ip_rst_n_o[sel_q]=1 and ip_clk_en_o[sel_q]=1.

Reset
REQ-035 arst_n_i low SHALL immediately force: state SAMPLE, ip_clk_en_o=0, ip_rst_n_o=0, pad_oe_en_o=0, ip_sel_q_o=0, err_o=0, sel_mismatch_o=0, all counters 0, synchronizer flops 0.
REQ-036 Reset asserted mid-sequence or in RUN SHALL take effect without passing through TEARDOWN.
REQ-037 After arst_n_i rises, the sequence SHALL restart from SAMPLE.

Verification
REQ-038 Boot: ip_sel_i=1 steady, ip_avail_i=8'h02, default params, reset released at cycle 0 -> ip_clk_en_o=8'h02 after 2+16 sampling cycles, ip_rst_n_o=8'h02 exactly 24 cycles later, pad_oe_en_o=1 4 cycles after that, state_o=4.
REQ-039 Glitchy select: ip_sel_i toggles 1->3->1 within SAMPLE -> stable counter clears on each change, ip_sel_q_o=1 latched only after 16 unchanged cycles.
REQ-040 Unavailable IP: ip_sel_i=5, ip_avail_i=8'h02 -> state_o=6, err_o=1, all enables 0; sw_restart_i pulse -> state_o=0, err_o=0.
REQ-041 Restart: sw_restart_i pulse in RUN -> same cycle pad_oe_en_o=0 and ip_rst_n_o=0, ip_clk_en_o=0 8 cycles later, new boot then follows.
REQ-042 Mismatch: ip_sel_i changed 1->2 in RUN -> sel_mismatch_o=1 3 cycles later, enables unchanged; sw_restart_i pulse -> reboot with IP 2.
REQ-043 Reset during RST_HOLD: arst_n_i low -> all outputs at reset values with no clock edge; state code 7 forced -> SAMPLE next cycle.
